// File: rtl/power_job_sequencer.sv
// power_job_sequencer: job FIFO + launch/complete sequencer in front of the 8-bit power engine.
//   Parameters: W (data width), DEPTH (job FIFO entries, power of two >= 2),
//               TIMEOUT_CYC (watchdog limit, only with POWER_SEQ_TIMEOUT_EN).
//   Optional feature macro: POWER_SEQ_TIMEOUT_EN enables the per-run watchdog and out_err.
//   Ports:
//     clk, rst                       clock, asynchronous active-high reset
//     in_valid/in_ready/in_a/in_b    job input stream (base, exponent)
//     eng_start/eng_a/eng_b          1-cycle start pulse and held operands to the engine
//     eng_busy/eng_result            engine status and result register
//     out_valid/out_ready/out_data   result output stream
//     out_err                        1 = run aborted by the watchdog (out_data = 0)
module power_job_sequencer #(
    parameter int W           = 8,
    parameter int DEPTH       = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         eng_start,
    output logic [W-1:0] eng_a,
    output logic [W-1:0] eng_b,
    input  logic         eng_busy,
    input  logic [W-1:0] eng_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("power_job_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 2");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  mem_a [DEPTH];
    logic [W-1:0]  mem_b [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          push, launch, done, abort;

    assign push      = in_valid & in_ready;
    assign count_nxt = count + CW'(push) - CW'(launch);

`ifdef POWER_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd_cnt;
    logic          err_q;
    // The run is aborted on the cycle whose increment would make the counter reach TIMEOUT_CYC.
    logic          wd_hit;
    assign wd_hit  = wd_cnt == TW'(TIMEOUT_CYC - 1);
    assign out_err = err_q;
`else
    logic          wd_hit;
    assign wd_hit  = 1'b0;
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // eng_busy is not looked at in IDLE: the engine's busy is unreset before its first run,
    // and a late busy edge from an aborted run must not be mistaken for a new run.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                launch    = (count != '0) && !out_valid;
                state_nxt = launch ? LAUNCH : IDLE;
            end
            LAUNCH: begin
                abort     = !eng_busy && wd_hit;
                state_nxt = eng_busy ? RUN : (abort ? IDLE : LAUNCH);
            end
            RUN: begin
                done      = !eng_busy;
                abort     = eng_busy && wd_hit;
                state_nxt = (done || abort) ? IDLE : RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready is registered from the next count, so a pop from a full FIFO frees the slot
    // only from the following cycle on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (launch)
                rd_ptr <= rd_ptr + AW'(1);
            count    <= count_nxt;
            in_ready <= count_nxt != CW'(DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_start <= 1'b0;
            eng_a     <= '0;
            eng_b     <= '0;
        end else begin
            eng_start <= launch;
            if (launch) begin
                eng_a <= mem_a[rd_ptr];
                eng_b <= mem_b[rd_ptr];
            end
        end
    end

    // A capture only happens while out_valid is low, so it never meets a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (done) begin
            out_valid <= 1'b1;
            out_data  <= eng_result;
        end else if (abort) begin
            out_valid <= 1'b1;
            out_data  <= '0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef POWER_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (launch)
                wd_cnt <= '0;
            else if (state != IDLE)
                wd_cnt <= wd_cnt + TW'(1);
            if (done)
                err_q <= 1'b0;
            else if (abort)
                err_q <= 1'b1;
        end
    end
`endif

endmodule
